// File: rtl/eq_lock_detector.sv
// -----------------------------------------------------------------------------
// eq_lock_detector
//
// Sequential consumer of a 2-bit equality comparator's aeqb result. Samples
// aeqb on qualified cycles (in_valid=1), declares lock after LOCK_CNT
// consecutive matches, and tolerates up to MISS_MAX consecutive mismatches
// while locked before dropping lock. Also keeps a saturating run-length
// counter and a saturating error counter for status readout.
//
// Parameters:
//   LOCK_CNT  consecutive valid matches required to enter lock (2..2^CNT_W-1)
//   MISS_MAX  consecutive valid mismatches tolerated while locked (0 = none)
//   CNT_W     width of run_len and err_cnt
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   aeqb is sampled only when high
//   aeqb       in   comparator result, 1 = inputs equal
//   clr_stats  in   synchronous clear of err_cnt (wins over an increment)
//   locked     out  high while in LOCKED or HOLD
//   lock_lost  out  one-cycle pulse on the edge where lock drops
//   run_len    out  consecutive valid matches, saturating
//   err_cnt    out  valid mismatches since reset/clear, saturating
// -----------------------------------------------------------------------------
module eq_lock_detector #(
  parameter int LOCK_CNT = 8,
  parameter int MISS_MAX = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             aeqb,
  input  logic             clr_stats,
  output logic             locked,
  output logic             lock_lost,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] err_cnt
);

  // Miss counter is at least 2 bits wide, wider only if MISS_MAX needs it.
  localparam int MISS_W = (MISS_MAX < 4) ? 2 : $clog2(MISS_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  LOCK_VAL = CNT_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [MISS_W-1:0]  miss, miss_nxt;
  logic [CNT_W-1:0]   run_nxt, err_nxt;
  logic               lost_nxt, locked_nxt;

  // ---------------------------------------------------------------------------
  // State and output registers. locked is registered from the next-state
  // decode so it never glitches on a state-encoding transition.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values and the order of statements does not matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      miss      <= '0;
      run_len   <= '0;
      err_cnt   <= '0;
      lock_lost <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      miss      <= miss_nxt;
      run_len   <= run_nxt;
      err_cnt   <= err_nxt;
      lock_lost <= lost_nxt;
      locked    <= locked_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first; without it a path
    // that skips an assignment would infer a latch.
    state_nxt = state;
    miss_nxt  = miss;
    run_nxt   = run_len;
    err_nxt   = err_cnt;
    lost_nxt  = 1'b0;

    if (in_valid) begin
      unique case (state)
        IDLE: begin
          if (aeqb) begin
            state_nxt = ACQ;
            run_nxt   = CNT_W'(1);
          end else begin
            run_nxt   = '0;
          end
        end

        ACQ: begin
          if (aeqb) begin
            run_nxt = run_len + 1'b1;
            if (run_nxt == LOCK_VAL) state_nxt = LOCKED;
          end else begin
            state_nxt = IDLE;
            run_nxt   = '0;
          end
        end

        LOCKED: begin
          if (aeqb) begin
            miss_nxt = '0;
            if (run_len != CNT_MAX) run_nxt = run_len + 1'b1;
          end else begin
            run_nxt = '0;
            if (MISS_MAX == 0) begin
              state_nxt = IDLE;
              lost_nxt  = 1'b1;
            end else begin
              state_nxt = HOLD;
              miss_nxt  = MISS_W'(1);
            end
          end
        end

        HOLD: begin
          if (aeqb) begin
            state_nxt = LOCKED;
            run_nxt   = CNT_W'(1);
            miss_nxt  = '0;
          end else begin
            run_nxt = '0;
            if (miss == MISS_LIM) begin
              state_nxt = IDLE;
              lost_nxt  = 1'b1;
              miss_nxt  = '0;
            end else begin
              miss_nxt  = miss + 1'b1;
            end
          end
        end

        default: begin
          state_nxt = IDLE;
          run_nxt   = '0;
          miss_nxt  = '0;
        end
      endcase
    end

    // Error counter: clear has priority over a same-cycle mismatch.
    if (clr_stats) begin
      err_nxt = '0;
    end else if (in_valid && !aeqb && (err_cnt != CNT_MAX)) begin
      err_nxt = err_cnt + 1'b1;
    end

    locked_nxt = (state_nxt == LOCKED) || (state_nxt == HOLD);
  end

endmodule

// File: tb/tb_eq_lock_detector.sv
// -----------------------------------------------------------------------------
// tb_eq_lock_detector
//
// Self-checking bench for eq_lock_detector with LOCK_CNT=4, MISS_MAX=2,
// CNT_W=4. Stimulus rows carry hand-derived expected outputs; each row's
// expectation is queued when its inputs are driven and popped for comparison
// once the DUT has registered the sample. A hand-written sequence covers the
// asynchronous reset asserted mid-hold.
// -----------------------------------------------------------------------------
module tb_eq_lock_detector;

  localparam int LOCK_CNT = 4;
  localparam int MISS_MAX = 2;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             aeqb;
  logic             clr_stats;
  logic             locked;
  logic             lock_lost;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] err_cnt;

  eq_lock_detector #(
    .LOCK_CNT(LOCK_CNT),
    .MISS_MAX(MISS_MAX),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .aeqb     (aeqb),
    .clr_stats(clr_stats),
    .locked   (locked),
    .lock_lost(lock_lost),
    .run_len  (run_len),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       a;
    logic       c;
    logic       lk;
    logic       ll;
    logic [3:0] run;
    logic [3:0] err;
  } vec_t;

  vec_t vecs[$];   // stimulus table for the current segment
  vec_t sb[$];     // scoreboard of pending expectations

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void add(input logic v, input logic a, input logic c,
                              input logic lk, input logic ll,
                              input int run, input int err);
    vec_t r;
    r.v = v; r.a = a; r.c = c;
    r.lk = lk; r.ll = ll;
    r.run = 4'(run); r.err = 4'(err);
    vecs.push_back(r);
  endfunction

  // Drive one row at the falling edge, then compare 1 time unit after the
  // rising edge that samples it.
  task automatic apply(input vec_t r, input string tag);
    vec_t e;
    @(negedge clk);
    in_valid  = r.v;
    aeqb      = r.a;
    clr_stats = r.c;
    sb.push_back(r);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " locked"},    {7'd0, locked},    {7'd0, e.lk});
      check({tag, " lock_lost"}, {7'd0, lock_lost}, {7'd0, e.ll});
      check({tag, " run_len"},   {4'd0, run_len},   {4'd0, e.run});
      check({tag, " err_cnt"},   {4'd0, err_cnt},   {4'd0, e.err});
    end
  endtask

  task automatic run_table(input string seg);
    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("%s row%0d", seg, i));
    vecs.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " locked"},    {7'd0, locked},    8'd0);
    check({tag, " lock_lost"}, {7'd0, lock_lost}, 8'd0);
    check({tag, " run_len"},   {4'd0, run_len},   8'd0);
    check({tag, " err_cnt"},   {4'd0, err_cnt},   8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    aeqb      = 1'b0;
    clr_stats = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Segment A: basic lock, drop after MISS_MAX+1, broken run, tolerated misses
    //    v  a  c  lk ll run err
    add(1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 2, 0);
    add(1, 1, 0, 0, 0, 3, 0);
    add(1, 1, 0, 1, 0, 4, 0);   // lock on the 4th match
    add(1, 0, 0, 1, 0, 0, 1);   // HOLD miss=1
    add(1, 0, 0, 1, 0, 0, 2);   // HOLD miss=2
    add(1, 0, 0, 0, 1, 0, 3);   // 3rd mismatch drops lock
    add(0, 0, 0, 0, 0, 0, 3);   // pulse ends, invalid X not counted
    add(1, 1, 0, 0, 0, 1, 3);   // M,M,X,M,M,M,M
    add(1, 1, 0, 0, 0, 2, 3);
    add(1, 0, 0, 0, 0, 0, 4);
    add(1, 1, 0, 0, 0, 1, 4);
    add(1, 1, 0, 0, 0, 2, 4);
    add(1, 1, 0, 0, 0, 3, 4);
    add(1, 1, 0, 1, 0, 4, 4);
    add(1, 0, 0, 1, 0, 0, 5);   // X,X,M stays locked
    add(1, 0, 0, 1, 0, 0, 6);
    add(1, 1, 0, 1, 0, 1, 6);
    add(1, 0, 0, 1, 0, 0, 7);   // X,X,X drops
    add(1, 0, 0, 1, 0, 0, 8);
    add(1, 0, 0, 0, 1, 0, 9);
    add(0, 0, 0, 0, 0, 0, 9);
    run_table("A");

    // Segment B: saturation of run_len and err_cnt, clear priority
    add(0, 0, 1, 0, 0, 0, 0);   // clear while idle
    for (int k = 1; k <= 4; k++) add(1, 1, 0, (k == 4), 0, k, 0);
    for (int k = 1; k <= 20; k++)
      add(1, 1, 0, 1, 0, (4 + k > 15) ? 15 : 4 + k, 0);
    for (int k = 1; k <= 17; k++)
      add(1, 0, 0, (k < 3), (k == 3), 0, (k > 15) ? 15 : k);
    add(1, 0, 1, 0, 0, 0, 0);   // clear beats mismatch
    add(1, 0, 0, 0, 0, 0, 1);
    run_table("B");

    // Segment C: idle gaps do not break a run or a miss sequence
    add(1, 1, 0, 0, 0, 1, 1);
    for (int k = 0; k < 5; k++) add(0, k[0], 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 2, 1);
    add(1, 1, 0, 0, 0, 3, 1);
    add(1, 1, 0, 1, 0, 4, 1);
    add(1, 0, 0, 1, 0, 0, 2);   // HOLD miss=1
    add(0, 0, 0, 1, 0, 0, 2);
    add(0, 1, 0, 1, 0, 0, 2);
    add(1, 0, 0, 1, 0, 0, 3);   // miss=2, still held
    add(0, 0, 0, 1, 0, 0, 3);
    add(1, 1, 0, 1, 0, 1, 3);   // recover
    add(1, 0, 0, 1, 0, 0, 4);   // HOLD miss=1 again
    run_table("C");

    // Hand sequence: reset asserted mid-cycle while in HOLD
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check_all_zero("async reset");
    @(posedge clk);
    #1;
    check_all_zero("reset held");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("after reset");

    // Segment D: miss counter cleared by reset -> needs 3 misses again
    for (int k = 1; k <= 4; k++) add(1, 1, 0, (k == 4), 0, k, 0);
    add(1, 0, 0, 1, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 2);
    add(1, 0, 0, 0, 1, 0, 3);
    add(1, 1, 0, 0, 0, 1, 3);
    run_table("D");

    check("scoreboard drained", 8'(sb.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eq_lock_detector.md
# eq_lock_detector

Sequential consumer of the 2-bit equality comparator's `aeqb` result. It samples the comparator output on qualified cycles and declares lock after `LOCK_CNT` consecutive matches. Once locked, it tolerates up to `MISS_MAX` consecutive mismatches before dropping lock. It also keeps a saturating run-length counter and a saturating error counter for status readout.

## Interface
Parameters:
- `LOCK_CNT`, default 8: consecutive valid matches required to enter lock. Legal range 2..2^CNT_W-1.
- `MISS_MAX`, default 2: consecutive valid mismatches tolerated while locked. 0 means drop lock on the first mismatch.
- `CNT_W`, default 8: width of `run_len` and `err_cnt`.

Ports:
- `clk`, input, 1: single clock; all logic uses the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: `aeqb` is sampled only when this is 1.
- `aeqb`, input, 1: comparator result; 1 = inputs equal.
- `clr_stats`, input, 1: synchronous clear of `err_cnt`.
- `locked`, output, 1: high in LOCKED and HOLD.
- `lock_lost`, output, 1: one-cycle pulse when lock drops.
- `run_len`, output, CNT_W: consecutive valid matches, saturating.
- `err_cnt`, output, CNT_W: total valid mismatches since reset or clear, saturating.

## Operation
- States: IDLE, ACQ, LOCKED, HOLD. A 2-bit `miss` counter (width ≥ clog2(MISS_MAX+1)) is held internally.
- Cycles with `in_valid`=0: no state change, no counter change, `lock_lost` = 0.
- IDLE, valid match: go to ACQ, `run_len`=1.
- IDLE, valid mismatch: stay in IDLE, `run_len`=0.
- ACQ, valid match: `run_len`+1. When the new value equals `LOCK_CNT`, go to LOCKED.
- ACQ, valid mismatch: go to IDLE, `run_len`=0.
- LOCKED, valid match: stay, `run_len` increments with saturation at 2^CNT_W-1, `miss`=0.
- LOCKED, valid mismatch: `run_len`=0.
  - If `MISS_MAX`=0: go to IDLE and pulse `lock_lost`.
  - Otherwise: go to HOLD with `miss`=1.
- HOLD, valid match: go to LOCKED, `run_len`=1, `miss`=0.
- HOLD, valid mismatch:
  - If `miss`=`MISS_MAX`: go to IDLE, pulse `lock_lost`, `miss`=0.
  - Otherwise: `miss`+1 and stay in HOLD.
- `err_cnt`: +1 on every valid mismatch in any state, saturating at 2^CNT_W-1 with no wrap.
- `clr_stats`=1: `err_cnt`=0. Clear wins over a simultaneous mismatch increment. `clr_stats` has no effect on the FSM or `run_len`.
- `locked` is decoded from the state register, so it is glitch-free and registered.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `locked`=0, `lock_lost`=0, `run_len`=0, `err_cnt`=0, `miss`=0.
- All outputs are registered and reflect the sample taken at edge N immediately after edge N. Latency is 1 cycle.
- `locked` rises on the same edge that samples the `LOCK_CNT`-th consecutive valid match.
- `lock_lost` is high for exactly one cycle, on the edge that samples the (`MISS_MAX`+1)-th consecutive mismatch. `locked` falls on that same edge. If the next cycle has no event, `lock_lost` returns to 0 regardless of `in_valid`.
- Idle gaps (`in_valid`=0) between samples do not break a run or a miss sequence.
- Reset asserted mid-acquire or mid-hold: everything clears asynchronously, and no `lock_lost` pulse is generated.
- No back-pressure: a sample is accepted on every cycle with `in_valid`=1.

## Test plan
All scenarios use `LOCK_CNT`=4, `MISS_MAX`=2, `CNT_W`=4.
1. Reset, then 4 valid matches back-to-back → `locked`=1 after the 4th edge, `run_len`=4, `err_cnt`=0.
2. Sequence M,M,X,M,M,M,M (M = match, X = mismatch) → return to IDLE at X with `run_len`=0. `locked` rises only after the final M, `run_len`=4, `err_cnt`=1.
3. Locked, then X,X,M → `locked` stays 1 throughout, no `lock_lost`, `run_len`=1, `err_cnt`=2. Then X,X,X → `lock_lost` pulses one cycle on the 3rd X, `locked`=0, `err_cnt`=5.
4. Locked, then 20 valid matches → `run_len` saturates at 15. Then 17 mismatches → `err_cnt` saturates at 15. `clr_stats` together with a mismatch → `err_cnt`=0.
5. M,M with `in_valid`=0 for 5 cycles between them, then M,M → lock is achieved. Outputs are frozen during the gaps.
6. In HOLD with `miss`=1, assert `reset` mid-cycle → all outputs are 0 immediately, with no `lock_lost` pulse.
